zx_tape_fastload: RTL and testbench
===================================

# zx_tape_fastload

Parametrised tape fast-loader for the ZX80/ZX81 core. It buffers a .o or .p image streamed over ioctl. When the CPU fetches the ROM LOAD entry, it overlays a 7-byte loop patch on the ROM read path and copies the buffered image into system RAM through a dedicated write port. It sits beside the RAM/ROM read mux in the core glue and replaces the inline tape logic. Over the single-speed version it adds configurable depth, base address and copy rate, overflow detection, correct one-cycle buffer read pipelining, and an abort on re-download.

## Interface
Parameters:
- BUF_AW, 14, buffer address width; depth = 2^BUF_AW bytes
- RAM_BASE, 16'h4000, RAM address of .o byte 0
- P_OFFSET, 9, extra offset for .p files (byte 0 → RAM_BASE+P_OFFSET)
- FAST, 0, 0 = one byte per ce_cpu_p; 1 = one byte per clk_sys

Ports:
- clk_sys in 1 system clock
- reset_n in 1 asynchronous active-low reset
- ioctl_wr in 1 download byte strobe
- ioctl_addr in 25 download byte address
- ioctl_dout in 8 download byte
- ioctl_download in 1 download in progress
- ioctl_index in 8 download file index
- zx81 in 1 1 = ZX81 ROM map, 0 = ZX80 ROM map
- cpu_addr in 16 Z80 address bus
- cpu_nm1 in 1 Z80 M1_n
- ce_cpu_p in 1 CPU positive clock enable
- patch_hit out 1 patch byte overrides ROM data this cycle
- patch_dout out 8 patch byte
- ram_we out 1 RAM write strobe, one clk_sys per byte
- ram_addr out 16 RAM write address
- ram_data out 8 RAM write data
- tape_ready out 1 buffered image size ≠ 0
- busy out 1 state ≠ IDLE
- overflow out 1 last image exceeded buffer depth

## Operation
- A download qualifies when ioctl_index[4:0]≠0, ioctl_index[7]=0 and ioctl_index[5]=0.
- Qualifying ioctl_wr: write ioctl_dout to buf[ioctl_addr[BUF_AW-1:0]] only when ioctl_addr < 2^BUF_AW. Higher addresses are dropped.
- Falling edge of ioctl_download on a qualifying download:
  - size ← min(ioctl_addr, 2^BUF_AW).
  - overflow ← (ioctl_addr > 2^BUF_AW).
  - type ← ioctl_index[6] (1 = .p).
- Rising edge of ioctl_download on a qualifying download while busy: abort to IDLE.
- Trap window, per zx81:
  - ZX81: LO = 16'h0347, HI = 16'h03C3, JMP = 16'h0207.
  - ZX80: LO = 16'h0207, HI = 16'h024D, JMP = 16'h0203.
- M1 fetch event: cpu_nm1 falling edge, detected against a registered copy.
- State machine: IDLE, PRIME, COPY, DONE.
  - IDLE → PRIME: M1 fetch at cpu_addr == LO. Clear rd_ptr and wr_cnt.
  - PRIME → COPY after 1 clk (buffer read latency). If size == 0, PRIME → DONE instead.
  - COPY: on each step (FAST ? 1 : ce_cpu_p), when wr_cnt < size, assert ram_we with data = buf[wr_cnt] and advance both pointers. When wr_cnt reaches size → DONE.
  - Any state ≠ IDLE → IDLE: M1 fetch with cpu_addr < LO or cpu_addr ≥ HI.
- ram_addr = RAM_BASE + (type ? P_OFFSET : 0) + wr_cnt, 16-bit wrap-around arithmetic.
- Patch bytes 0..6 are AF, B1, 30, FD, C3, JMP[7:0], JMP[15:8].
  - B1 = 00 (nop) in PRIME/COPY and 37 (scf) in DONE.
- patch_hit = (state ≠ IDLE) & (LO ≤ cpu_addr ≤ LO+6). patch_dout = patch[cpu_addr-LO]. Both are combinational from cpu_addr.

## Timing
- Reset values: state IDLE, size 0, type 0, overflow 0, and all outputs 0.
- Buffer read is synchronous with 1-clk latency. The read address runs one step ahead so ram_data is always the byte for the current ram_addr. Duplicated or skipped bytes are forbidden.
- Copy time: FAST=1 takes size clk_sys; FAST=0 takes size ce_cpu_p pulses, plus 1 PRIME clk in both cases.
- Trap exit during COPY: ram_we is 0 from the next clk onward and no partial byte is written. Trap exit takes priority over a same-cycle copy step.
- Reset mid-copy: outputs clear immediately (asynchronous).
- Buffer contents are not cleared by reset.
- A trap during an ongoing download copies the current size, which still holds the previous image.

## Structure
- Package zx_tape_pkg holds:
  - the state enum;
  - the LO/HI/JMP constants for both machines;
  - the patch template;
  - the qualifying-index function.
- The buffer is the existing dpram: port B is ioctl write, port A is copy read, ADDRWIDTH = BUF_AW.
- Sub-module zx_tape_trap holds the M1 edge detector and window compare.

## Test plan
- .p image of 100 bytes, zx81=1, FAST=0, M1 fetch at 0347 → 100 ram_we pulses at 4009..406C, data matches file, then patch_dout at 0348 = 37.
- .o image of 16 bytes, zx81=0, FAST=1, M1 fetch at 0207 → writes at 4000..400F on 16 consecutive clk, patch at 020C/020D = 03/02.
- 2^BUF_AW+5 byte download → overflow=1, size=2^BUF_AW, last written address RAM_BASE+2^BUF_AW-1 (.o).
- Mid-copy M1 fetch at 0000 → ram_we 0 the next clk, busy=0, patch_hit 0 at 0347.
- reset_n low mid-copy → all outputs 0 asynchronously; with size=0, a trap goes straight to DONE (patch byte 1 = 37, no writes).

Source files
------------

// File: rtl/zx_tape_pkg.sv
// Shared definitions for the ZX80/ZX81 tape fast-loader: FSM states,
// ROM trap windows for both machines and the LOAD-loop patch bytes.
package zx_tape_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_COPY  = 2'd2,
    ST_DONE  = 2'd3
  } tape_st_e;

  // ZX81 ROM: LOAD entry, end of the tape routine, and re-entry target
  localparam logic [15:0] ZX81_LO  = 16'h0347;
  localparam logic [15:0] ZX81_HI  = 16'h03C3;
  localparam logic [15:0] ZX81_JMP = 16'h0207;

  // ZX80 ROM equivalents
  localparam logic [15:0] ZX80_LO  = 16'h0207;
  localparam logic [15:0] ZX80_HI  = 16'h024D;
  localparam logic [15:0] ZX80_JMP = 16'h0203;

  // Patch template: xor a / nop|scf / jr nc,-3 / ... / jp JMP
  localparam int          PATCH_LEN     = 7;
  localparam logic [7:0]  PATCH_B0      = 8'hAF;
  localparam logic [7:0]  PATCH_B1_RUN  = 8'h00;
  localparam logic [7:0]  PATCH_B1_DONE = 8'h37;
  localparam logic [7:0]  PATCH_B2      = 8'h30;
  localparam logic [7:0]  PATCH_B3      = 8'hFD;
  localparam logic [7:0]  PATCH_B4      = 8'hC3;

  // A download is a tape image when the slot is non-zero and bits 7 and 5 are clear
  function automatic logic tape_index_ok(input logic [7:0] idx);
    return (idx[4:0] != 5'd0) && ((idx & 8'hA0) == 8'h00);
  endfunction

  // Patch byte at offset idx; byte 1 flips to scf once the copy has finished
  function automatic logic [7:0] patch_byte(input logic [2:0]  idx,
                                            input logic        done,
                                            input logic [15:0] jmp);
    logic [7:0] b;
    case (idx)
      3'd0:    b = PATCH_B0;
      3'd1:    b = done ? PATCH_B1_DONE : PATCH_B1_RUN;
      3'd2:    b = PATCH_B2;
      3'd3:    b = PATCH_B3;
      3'd4:    b = PATCH_B4;
      3'd5:    b = jmp[7:0];
      3'd6:    b = jmp[15:8];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dpram.sv
// Simple dual-port RAM: port B writes, port A reads with one clock latency.
module dpram #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 8
) (
  input  logic                 clock,
  input  logic [ADDRWIDTH-1:0] address_a,
  output logic [DATAWIDTH-1:0] q_a,
  input  logic [ADDRWIDTH-1:0] address_b,
  input  logic [DATAWIDTH-1:0] data_b,
  input  logic                 wren_b
);

  logic [DATAWIDTH-1:0] mem [2**ADDRWIDTH];

  // Registered read on A, write on B; contents are never cleared
  always_ff @(posedge clock) begin
    if (wren_b) mem[address_b] <= data_b;
    q_a <= mem[address_a];
  end

endmodule

// File: rtl/zx_tape_trap.sv
// M1 fetch detector and ROM trap-window decode for the tape fast-loader.
module zx_tape_trap
  import zx_tape_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        zx81,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_nm1,
  output logic        m1_fetch,
  output logic        at_lo,
  output logic        outside,
  output logic        in_patch,
  output logic [2:0]  patch_idx,
  output logic [15:0] jmp
);

  logic        nm1_q;
  logic [15:0] lo;
  logic [15:0] hi;
  logic [15:0] ofs;

  // Delayed M1_n so a falling edge is seen exactly once per fetch
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) nm1_q <= 1'b1;
    else          nm1_q <= cpu_nm1;
  end

  // Window constants per machine and the address compares against them
  always_comb begin
    lo        = zx81 ? ZX81_LO  : ZX80_LO;
    hi        = zx81 ? ZX81_HI  : ZX80_HI;
    jmp       = zx81 ? ZX81_JMP : ZX80_JMP;
    ofs       = cpu_addr - lo;
    m1_fetch  = nm1_q & ~cpu_nm1;
    at_lo     = (cpu_addr == lo);
    outside   = (cpu_addr < lo) || (cpu_addr >= hi);
    in_patch  = (cpu_addr >= lo) && (ofs < 16'(PATCH_LEN));
    patch_idx = ofs[2:0];
  end

endmodule

// File: rtl/zx_tape_fastload.sv
// ZX80/ZX81 tape fast-loader: buffers a downloaded .o/.p image, traps the
// ROM LOAD entry, overlays a short wait loop on the ROM read path and copies
// the image into system RAM through a dedicated write port.
module zx_tape_fastload
  import zx_tape_pkg::*;
#(
  parameter int          BUF_AW   = 14,
  parameter logic [15:0] RAM_BASE = 16'h4000,
  parameter int          P_OFFSET = 9,
  parameter bit          FAST     = 1'b0
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        zx81,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_nm1,
  input  logic        ce_cpu_p,
  output logic        patch_hit,
  output logic [7:0]  patch_dout,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        tape_ready,
  output logic        busy,
  output logic        overflow
);

  localparam logic [24:0]   DEPTH25 = 25'd1 << BUF_AW;
  localparam logic [BUF_AW:0] DEPTH_SZ = {1'b1, {BUF_AW{1'b0}}};
  localparam logic [15:0]   P_OFF16 = 16'(P_OFFSET);

  tape_st_e          state;
  tape_st_e          state_nx;
  logic              dl_q;
  logic [BUF_AW:0]   size;
  logic              is_p;
  logic              ovf;
  logic [BUF_AW:0]   wr_cnt;
  logic [BUF_AW-1:0] rd_ptr;
  logic [BUF_AW-1:0] rd_addr_p0;
  logic [7:0]        rd_data_p1;
  logic              qual;
  logic              buf_we;
  logic              dl_fall;
  logic              dl_rise;
  logic              step;
  logic              step_en;
  logic              trap_exit;
  logic [15:0]       base_addr;

  logic              m1_fetch;
  logic              at_lo;
  logic              outside;
  logic              in_patch;
  logic [2:0]        patch_idx;
  logic [15:0]       jmp;

  // Image size clamps at the buffer depth; anything beyond it was dropped
  function automatic logic [BUF_AW:0] clamp_size(input logic [24:0] a);
    if (a >= DEPTH25) return DEPTH_SZ;
    return a[BUF_AW:0];
  endfunction

  zx_tape_trap u_trap (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .zx81      (zx81),
    .cpu_addr  (cpu_addr),
    .cpu_nm1   (cpu_nm1),
    .m1_fetch  (m1_fetch),
    .at_lo     (at_lo),
    .outside   (outside),
    .in_patch  (in_patch),
    .patch_idx (patch_idx),
    .jmp       (jmp)
  );

  // Download qualification and edge strobes
  always_comb begin
    qual    = tape_index_ok(ioctl_index);
    buf_we  = ioctl_wr && qual && (ioctl_addr < DEPTH25);
    dl_fall = dl_q && !ioctl_download && qual;
    dl_rise = !dl_q && ioctl_download && qual;
  end

  // Stage p0: buffer read address, one step ahead whenever a byte is consumed
  assign rd_addr_p0 = rd_ptr + {{(BUF_AW-1){1'b0}}, step};

  dpram #(
    .DATAWIDTH (8),
    .ADDRWIDTH (BUF_AW)
  ) u_buf (
    .clock     (clk_sys),
    .address_a (rd_addr_p0),
    .q_a       (rd_data_p1),
    .address_b (ioctl_addr[BUF_AW-1:0]),
    .data_b    (ioctl_dout),
    .wren_b    (buf_we)
  );
  // Stage p1: rd_data_p1 always holds buf[wr_cnt] while copying

  // Latch image size, type and overflow when a tape download completes
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_q <= 1'b0;
      size <= '0;
      is_p <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      dl_q <= ioctl_download;
      if (dl_fall) begin
        size <= clamp_size(ioctl_addr);
        ovf  <= (ioctl_addr > DEPTH25);
        is_p <= ioctl_index[6];
      end
    end
  end

  // Next-state logic; leaving the trap window or re-downloading beats a copy step
  always_comb begin
    state_nx  = state;
    step      = 1'b0;
    step_en   = FAST ? 1'b1 : ce_cpu_p;
    trap_exit = (state != ST_IDLE) && ((m1_fetch && outside) || dl_rise);
    case (state)
      ST_IDLE: begin
        if (m1_fetch && at_lo) state_nx = ST_PRIME;
      end
      ST_PRIME: begin
        state_nx = (size == '0) ? ST_DONE : ST_COPY;
      end
      ST_COPY: begin
        if (wr_cnt < size) begin
          if (step_en) begin
            step = 1'b1;
            if ((wr_cnt + 1'b1) == size) state_nx = ST_DONE;
          end
        end else begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nx = ST_DONE;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (trap_exit) begin
      state_nx = ST_IDLE;
      step     = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Copy pointers: cleared on trap entry, advanced together per byte
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt <= '0;
      rd_ptr <= '0;
    end else if (state == ST_IDLE && state_nx == ST_PRIME) begin
      wr_cnt <= '0;
      rd_ptr <= '0;
    end else if (step) begin
      wr_cnt <= wr_cnt + 1'b1;
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // RAM write port and status outputs; address/data only driven with the strobe
  always_comb begin
    base_addr  = RAM_BASE + (is_p ? P_OFF16 : 16'h0000);
    ram_we     = step;
    ram_addr   = step ? (base_addr + 16'(wr_cnt)) : 16'h0000;
    ram_data   = step ? rd_data_p1 : 8'h00;
    tape_ready = (size != '0);
    busy       = (state != ST_IDLE);
    overflow   = ovf;
  end

  // ROM overlay: patch bytes replace ROM data at LO..LO+6 while trapped
  always_comb begin
    patch_hit  = (state != ST_IDLE) && in_patch;
    patch_dout = patch_hit ? patch_byte(patch_idx, state == ST_DONE, jmp) : 8'h00;
  end

endmodule

// File: tb/tb_zx_tape_fastload.sv
// Directed bench for zx_tape_fastload: one slow-copy and one fast-copy
// instance share all inputs and are checked against hand-computed values.
module tb_zx_tape_fastload;

  localparam int AW = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        zx81;
  logic [15:0] cpu_addr;
  logic        cpu_nm1;
  logic        ce_cpu_p;

  logic        patch_hit0, patch_hit1;
  logic [7:0]  patch_dout0, patch_dout1;
  logic        ram_we0, ram_we1;
  logic [15:0] ram_addr0, ram_addr1;
  logic [7:0]  ram_data0, ram_data1;
  logic        tape_ready0, tape_ready1;
  logic        busy0, busy1;
  logic        overflow0, overflow1;

  zx_tape_fastload #(.BUF_AW(AW), .RAM_BASE(16'h4000), .P_OFFSET(9), .FAST(1'b0)) dut0 (
    .clk_sys(clk), .reset_n(reset_n), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .zx81(zx81), .cpu_addr(cpu_addr), .cpu_nm1(cpu_nm1), .ce_cpu_p(ce_cpu_p),
    .patch_hit(patch_hit0), .patch_dout(patch_dout0), .ram_we(ram_we0),
    .ram_addr(ram_addr0), .ram_data(ram_data0), .tape_ready(tape_ready0),
    .busy(busy0), .overflow(overflow0)
  );

  zx_tape_fastload #(.BUF_AW(AW), .RAM_BASE(16'h4000), .P_OFFSET(9), .FAST(1'b1)) dut1 (
    .clk_sys(clk), .reset_n(reset_n), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .zx81(zx81), .cpu_addr(cpu_addr), .cpu_nm1(cpu_nm1), .ce_cpu_p(ce_cpu_p),
    .patch_hit(patch_hit1), .patch_dout(patch_dout1), .ram_we(ram_we1),
    .ram_addr(ram_addr1), .ram_data(ram_data1), .tape_ready(tape_ready1),
    .busy(busy1), .overflow(overflow1)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write logs for both instances
  logic [15:0] w0_addr [1024];
  logic [7:0]  w0_data [1024];
  int          w0_cyc  [1024];
  int          n0 = 0;
  logic [15:0] w1_addr [1024];
  logic [7:0]  w1_data [1024];
  int          w1_cyc  [1024];
  int          n1 = 0;

  always @(negedge clk) begin
    if (ram_we0 && n0 < 1024) begin
      w0_addr[n0] <= ram_addr0;
      w0_data[n0] <= ram_data0;
      w0_cyc[n0]  <= cyc;
      n0          <= n0 + 1;
    end
    if (ram_we1 && n1 < 1024) begin
      w1_addr[n1] <= ram_addr1;
      w1_data[n1] <= ram_data1;
      w1_cyc[n1]  <= cyc;
      n1          <= n1 + 1;
    end
  end

  // CPU clock enable: one pulse every fourth clk_sys
  initial begin
    ce_cpu_p = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ce_cpu_p = (cyc % 4 == 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fetch_cyc = 0;
  logic [7:0] img [512];

  typedef struct {
    logic [15:0] addr;
    logic        hit0;
    logic [7:0]  d0;
    logic        hit1;
    logic [7:0]  d1;
  } pvec_t;
  pvec_t tbl [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] pat(input int kind, input int i);
    if (kind == 0) return 8'(i * 7 + 3);
    return 8'(i) ^ ((i >= 256) ? 8'hFF : 8'h00);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic download(input logic [7:0] idx, input int len, input int kind);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < len; i++) begin
      ioctl_addr = 25'(i);
      ioctl_dout = pat(kind, i);
      ioctl_wr   = 1'b1;
      if (i < 512) img[i] = pat(kind, i);
      tick();
      ioctl_wr = 1'b0;
    end
    ioctl_addr = 25'(len);
    tick();
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic m1(input logic [15:0] a);
    cpu_addr  = a;
    cpu_nm1   = 1'b0;
    fetch_cyc = cyc;
    tick();
    cpu_nm1 = 1'b1;
  endtask

  task automatic wait_n(input int which, input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (((which != 0) ? n1 : n0) >= target) break;
      tick();
    end
    tick();
  endtask

  task automatic check_run(input int which, input int base, input int cnt,
                           input logic [15:0] a0, input string tag);
    int bad;
    logic [15:0] a;
    logic [7:0]  d;
    bad = 0;
    for (int i = 0; i < cnt; i++) begin
      if (base + i >= 1024) begin
        bad++;
      end else begin
        a = (which != 0) ? w1_addr[base+i] : w0_addr[base+i];
        d = (which != 0) ? w1_data[base+i] : w0_data[base+i];
        if (a !== a0 + 16'(i) || d !== img[i]) bad++;
      end
    end
    chk({tag, "_bad_bytes"}, bad, 0);
  endtask

  task automatic run_table(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      cpu_addr = tbl[i].addr;
      #1;
      chk($sformatf("tbl%0d_hit0", i), patch_hit0, tbl[i].hit0);
      chk($sformatf("tbl%0d_dout0", i), patch_dout0, tbl[i].d0);
      chk($sformatf("tbl%0d_hit1", i), patch_hit1, tbl[i].hit1);
      chk($sformatf("tbl%0d_dout1", i), patch_dout1, tbl[i].d1);
    end
  endtask

  int b0, b1, nb0, nb1;

  initial begin
    // ZX81 window, both instances in DONE after a .p copy
    tbl[0]  = '{16'h0346, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[1]  = '{16'h0347, 1'b1, 8'hAF, 1'b1, 8'hAF};
    tbl[2]  = '{16'h0348, 1'b1, 8'h37, 1'b1, 8'h37};
    tbl[3]  = '{16'h0349, 1'b1, 8'h30, 1'b1, 8'h30};
    tbl[4]  = '{16'h034A, 1'b1, 8'hFD, 1'b1, 8'hFD};
    tbl[5]  = '{16'h034B, 1'b1, 8'hC3, 1'b1, 8'hC3};
    tbl[6]  = '{16'h034C, 1'b1, 8'h07, 1'b1, 8'h07};
    tbl[7]  = '{16'h034D, 1'b1, 8'h02, 1'b1, 8'h02};
    tbl[8]  = '{16'h034E, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[9]  = '{16'h03C2, 1'b0, 8'h00, 1'b0, 8'h00};
    // ZX80 window, slow instance still copying, fast instance done
    tbl[10] = '{16'h0206, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[11] = '{16'h0207, 1'b1, 8'hAF, 1'b1, 8'hAF};
    tbl[12] = '{16'h0208, 1'b1, 8'h00, 1'b1, 8'h37};
    tbl[13] = '{16'h0209, 1'b1, 8'h30, 1'b1, 8'h30};
    tbl[14] = '{16'h020A, 1'b1, 8'hFD, 1'b1, 8'hFD};
    tbl[15] = '{16'h020B, 1'b1, 8'hC3, 1'b1, 8'hC3};
    tbl[16] = '{16'h020C, 1'b1, 8'h03, 1'b1, 8'h03};
    tbl[17] = '{16'h020D, 1'b1, 8'h02, 1'b1, 8'h02};
    tbl[18] = '{16'h020E, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[19] = '{16'h024C, 1'b0, 8'h00, 1'b0, 8'h00};

    reset_n = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    ioctl_download = 1'b0; ioctl_index = 8'h00; zx81 = 1'b1;
    cpu_addr = 16'h0347; cpu_nm1 = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_busy0", busy0, 0);
    chk("rst_ready0", tape_ready0, 0);
    chk("rst_ovf0", overflow0, 0);
    chk("rst_we0", ram_we0, 0);
    chk("rst_addr0", ram_addr0, 0);
    chk("rst_hit0", patch_hit0, 0);
    chk("rst_hit1", patch_hit1, 0);
    reset_n = 1'b1;
    tick();

    // .p image, 100 bytes, ZX81
    zx81 = 1'b1;
    download(8'h41, 100, 0);
    chk("p_ready0", tape_ready0, 1);
    chk("p_ovf0", overflow0, 0);
    chk("p_idle_hit0", patch_hit0, 0);
    b0 = n0; b1 = n1;
    m1(16'h0347);
    wait_n(0, b0 + 100, 520);
    chk("p_cnt0", n0 - b0, 100);
    check_run(0, b0, 100, 16'h4009, "p_run0");
    chk("p_last_addr0", w0_addr[b0+99], 16'h406C);
    chk("p_cnt1", n1 - b1, 100);
    check_run(1, b1, 100, 16'h4009, "p_run1");
    chk("p_first1", w1_cyc[b1] - fetch_cyc, 2);
    chk("p_busy0", busy0, 1);
    run_table(0, 9);
    tick();
    m1(16'h0000);
    chk("p_exit_busy0", busy0, 0);
    chk("p_exit_busy1", busy1, 0);

    // .o image, 16 bytes, ZX80
    zx81 = 1'b0;
    download(8'h01, 16, 0);
    b0 = n0; b1 = n1;
    m1(16'h0207);
    wait_n(1, b1 + 16, 40);
    chk("o_cnt1", n1 - b1, 16);
    check_run(1, b1, 16, 16'h4000, "o_run1");
    chk("o_first1", w1_cyc[b1] - fetch_cyc, 2);
    chk("o_span1", w1_cyc[b1+15] - w1_cyc[b1], 15);
    run_table(10, 19);
    tick();

    // Mid-copy trap exit on the slow instance
    nb0 = n0;
    chk("abort_started0", (n0 > b0) ? 1 : 0, 1);
    m1(16'h0000);
    chk("abort_we0", ram_we0, 0);
    chk("abort_busy0", busy0, 0);
    repeat (20) tick();
    chk("abort_no_more0", n0 - nb0, 0);
    chk("abort_partial0", ((n0 - b0) < 16) ? 1 : 0, 1);
    check_run(0, b0, n0 - b0, 16'h4000, "abort_run0");
    zx81 = 1'b1;
    cpu_addr = 16'h0347;
    #1;
    chk("abort_hit0", patch_hit0, 0);
    tick();

    // Oversized image: 2^AW + 5 bytes
    zx81 = 1'b0;
    download(8'h01, (1 << AW) + 5, 1);
    chk("ovf_flag1", overflow1, 1);
    chk("ovf_flag0", overflow0, 1);
    chk("ovf_ready1", tape_ready1, 1);
    b1 = n1;
    m1(16'h0207);
    wait_n(1, b1 + 256, 300);
    repeat (5) tick();
    chk("ovf_cnt1", n1 - b1, 256);
    check_run(1, b1, 256, 16'h4000, "ovf_run1");
    chk("ovf_last_addr1", w1_addr[b1+255], 16'h40FF);
    chk("ovf_first_data1", w1_data[b1], 8'h00);
    m1(16'h0000);
    tick();

    // Asynchronous reset in the middle of a fast copy
    m1(16'h0207);
    repeat (10) tick();
    chk("rstmid_pre_we1", ram_we1, 1);
    reset_n = 1'b0;
    #1;
    chk("rstmid_we1", ram_we1, 0);
    chk("rstmid_addr1", ram_addr1, 0);
    chk("rstmid_data1", ram_data1, 0);
    chk("rstmid_busy1", busy1, 0);
    chk("rstmid_hit1", patch_hit1, 0);
    chk("rstmid_ovf1", overflow1, 0);
    chk("rstmid_ready1", tape_ready1, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Empty image after reset: trap goes straight to DONE
    nb1 = n1;
    m1(16'h0207);
    cpu_addr = 16'h0208;
    tick();
    tick();
    chk("empty_busy1", busy1, 1);
    chk("empty_hit1", patch_hit1, 1);
    chk("empty_b1_1", patch_dout1, 8'h37);
    chk("empty_writes1", n1 - nb1, 0);

    // A new tape download while trapped aborts to IDLE
    ioctl_index    = 8'h01;
    ioctl_download = 1'b1;
    tick();
    chk("redl_busy1", busy1, 0);
    ioctl_addr     = '0;
    ioctl_download = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
